// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU op codes, FSM states and
// the helper that classifies op codes the ALU does not implement.
package alu_share_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Codes with no ALU function; they can bypass the ALU when op checking is built in.
    function automatic logic op_is_reserved(input logic [2:0] op);
        case (op)
            3'b100, 3'b110, 3'b111: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU bundle of alu_share_arbiter. resp_err exists only
// when ALU_SHARE_OPCHECK_EN is defined.
interface alu_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*3-1:0]     req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_result;
    logic                  resp_zero;
`ifdef ALU_SHARE_OPCHECK_EN
    logic                  resp_err;
`endif
    logic [WIDTH-1:0]      alu_srca;
    logic [WIDTH-1:0]      alu_srcb;
    logic [2:0]            alu_ctrl;
    logic [WIDTH-1:0]      alu_result;
    logic                  alu_zero;

    // Requesters, response consumer and the shared ALU.
    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_zero,
        input  req_ready, resp_valid, resp_id, resp_result, resp_zero,
`ifdef ALU_SHARE_OPCHECK_EN
        input  resp_err,
`endif
        input  alu_srca, alu_srcb, alu_ctrl
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_zero,
        output req_ready, resp_valid, resp_id, resp_result, resp_zero,
`ifdef ALU_SHARE_OPCHECK_EN
        output resp_err,
`endif
        output alu_srca, alu_srcb, alu_ctrl
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // Scan from ptr, keeping only the first hit.
    always_comb begin : scan
        int   idx;
        logic hit;
        grant     = {N{1'b0}};
        grant_idx = {IW{1'b0}};
        any       = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx        = (int'(ptr) + i) % N;
            hit        = !any && req[idx];
            grant[idx] = grant[idx] | hit;
            grant_idx  = hit ? IW'(idx) : grant_idx;
            any        = any | hit;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one single-cycle ALU between NREQ requesters, one
// transaction in flight. Optional macro ALU_SHARE_OPCHECK_EN adds resp_err.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = ALU_W,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);

    state_e            state_r, next_state_s;
    logic [IDW-1:0]    rr_ptr_r, g_r, grant_idx_s;
    logic [NREQ-1:0]   grant_s, req_ready_s;
    logic              any_s, skip_s;
    logic [2:0]        op_sel_s;
    logic [WIDTH-1:0]  a_sel_s, b_sel_s;
    logic              resp_valid_r, resp_zero_r;
    logic [IDW-1:0]    resp_id_r;
    logic [WIDTH-1:0]  resp_result_r, alu_srca_r, alu_srcb_r;
    logic [2:0]        alu_ctrl_r;
`ifdef ALU_SHARE_OPCHECK_EN
    logic              resp_err_r;
`endif

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    assign op_sel_s = bus.req_op[int'(grant_idx_s) * 32'd3 +: 3];
    assign a_sel_s  = bus.req_a[int'(grant_idx_s) * WIDTH +: WIDTH];
    assign b_sel_s  = bus.req_b[int'(grant_idx_s) * WIDTH +: WIDTH];
`ifdef ALU_SHARE_OPCHECK_EN
    assign skip_s   = op_is_reserved(op_sel_s);
`else
    assign skip_s   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and the combinational accept strobe.
    always_comb begin
        next_state_s = state_r;
        req_ready_s  = {NREQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    req_ready_s  = grant_s;
                    next_state_s = skip_s ? RESP : ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: next_state_s = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Transaction datapath: operand latch, response capture and pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r      <= {IDW{1'b0}};
            g_r           <= {IDW{1'b0}};
            resp_valid_r  <= 1'b0;
            resp_id_r     <= {IDW{1'b0}};
            resp_result_r <= {WIDTH{1'b0}};
            resp_zero_r   <= 1'b0;
            alu_srca_r    <= {WIDTH{1'b0}};
            alu_srcb_r    <= {WIDTH{1'b0}};
            alu_ctrl_r    <= 3'b000;
`ifdef ALU_SHARE_OPCHECK_EN
            resp_err_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        g_r <= grant_idx_s;
                        if (skip_s) begin
                            // Reserved op: answer directly, ALU drives untouched.
                            resp_valid_r  <= 1'b1;
                            resp_id_r     <= grant_idx_s;
                            resp_result_r <= {WIDTH{1'b0}};
                            resp_zero_r   <= 1'b0;
`ifdef ALU_SHARE_OPCHECK_EN
                            resp_err_r    <= 1'b1;
`endif
                        end else begin
                            alu_srca_r <= a_sel_s;
                            alu_srcb_r <= b_sel_s;
                            alu_ctrl_r <= op_sel_s;
                        end
                    end
                end
                ISSUE: begin
                    resp_valid_r  <= 1'b1;
                    resp_id_r     <= g_r;
                    resp_result_r <= bus.alu_result;
                    resp_zero_r   <= bus.alu_zero;
`ifdef ALU_SHARE_OPCHECK_EN
                    resp_err_r    <= 1'b0;
`endif
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        rr_ptr_r     <= (g_r == IDW'(NREQ - 1)) ? {IDW{1'b0}} : g_r + IDW'(1);
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Accept strobe is forced low while reset is asserted.
    assign bus.req_ready   = req_ready_s & {NREQ{rst_n}};
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_id     = resp_id_r;
    assign bus.resp_result = resp_result_r;
    assign bus.resp_zero   = resp_zero_r;
    assign bus.alu_srca    = alu_srca_r;
    assign bus.alu_srcb    = alu_srcb_r;
    assign bus.alu_ctrl    = alu_ctrl_r;
`ifdef ALU_SHARE_OPCHECK_EN
    assign bus.resp_err    = resp_err_r;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (NREQ=4, WIDTH=32),
// with a behavioural single-cycle ALU attached to the alu_* ports.
module tb_alu_share_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    alu_share_arbiter_if #(.NREQ(4), .WIDTH(32)) bus ();

    alu_share_arbiter #(.NREQ(4), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural shared ALU.
    always_comb begin
        case (bus.alu_ctrl)
            3'b000:  bus.alu_result = bus.alu_srca + bus.alu_srcb;
            3'b001:  bus.alu_result = bus.alu_srca - bus.alu_srcb;
            3'b010:  bus.alu_result = bus.alu_srca & bus.alu_srcb;
            3'b011:  bus.alu_result = bus.alu_srca | bus.alu_srcb;
            3'b101:  bus.alu_result = ($signed(bus.alu_srca) < $signed(bus.alu_srcb)) ? 32'd1 : 32'd0;
            default: bus.alu_result = 32'd0;
        endcase
    end
    assign bus.alu_zero = (bus.alu_result == 32'd0);

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[i*3 +: 3] = op;
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Checks the response of a transaction accepted two cycles earlier.
    task automatic check_resp(input string tag, input logic [1:0] id, input logic [31:0] res, input logic zf);
        check_val({tag, "_valid"}, {63'd0, bus.resp_valid}, 64'd1);
        check_val({tag, "_id"}, {62'd0, bus.resp_id}, {62'd0, id});
        check_val({tag, "_result"}, {32'd0, bus.resp_result}, {32'd0, res});
        check_val({tag, "_zero"}, {63'd0, bus.resp_zero}, {63'd0, zf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  exp_id  [5];
        logic [31:0] exp_res [5];
        logic        exp_z   [5];
        logic [3:0]  onehot;
        int          g;
        int          cyc;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req_valid  = 4'b0000;
        bus.req_op     = 12'd0;
        bus.req_a      = 128'd0;
        bus.req_b      = 128'd0;
        bus.resp_ready = 1'b1;

        // Reset values
        #12;
        check_val("rst_req_ready", {60'd0, bus.req_ready}, 64'd0);
        check_val("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check_val("rst_resp_id", {62'd0, bus.resp_id}, 64'd0);
        check_val("rst_resp_result", {32'd0, bus.resp_result}, 64'd0);
        check_val("rst_resp_zero", {63'd0, bus.resp_zero}, 64'd0);
        check_val("rst_alu_srca", {32'd0, bus.alu_srca}, 64'd0);
        check_val("rst_alu_srcb", {32'd0, bus.alu_srcb}, 64'd0);
        check_val("rst_alu_ctrl", {61'd0, bus.alu_ctrl}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single request: 5 + 7
        set_req(0, 3'b000, 32'd5, 32'd7);
        bus.req_valid = 4'b0001;
        #1;
        check_val("single_ready_T", {60'd0, bus.req_ready}, 64'h1);
        step();
        check_val("single_ready_T1", {60'd0, bus.req_ready}, 64'h0);
        check_val("single_valid_T1", {63'd0, bus.resp_valid}, 64'd0);
        check_val("single_srca", {32'd0, bus.alu_srca}, 64'd5);
        check_val("single_srcb", {32'd0, bus.alu_srcb}, 64'd7);
        check_val("single_ctrl", {61'd0, bus.alu_ctrl}, 64'd0);
        bus.req_valid = 4'b0000;
        step();
        check_resp("single", 2'd0, 32'd12, 1'b0);
        step();
        check_val("single_done", {63'd0, bus.resp_valid}, 64'd0);

        // Four simultaneous requesters, strict rotation from pointer 0
        do_reset();
        set_req(0, 3'b001, 32'd9, 32'd9);
        set_req(1, 3'b101, 32'd3, 32'd8);
        set_req(2, 3'b010, 32'hF0, 32'h3C);
        set_req(3, 3'b011, 32'hF0, 32'h0F);
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_res = '{32'd0, 32'd1, 32'h30, 32'hFF, 32'd3};
        exp_z   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            while (bus.req_ready == 4'b0000 && cyc < 10) begin
                step();
                cyc++;
            end
            onehot = 4'b0001 << exp_id[k];
            check_val("rot_grant", {60'd0, bus.req_ready}, {60'd0, onehot});
            g = 0;
            for (int j = 0; j < 4; j++) begin
                if (bus.req_ready[j]) g = j;
            end
            step();
            if (k == 0) set_req(0, 3'b000, 32'd1, 32'd2);
            else bus.req_valid[g] = 1'b0;
            step();
            check_resp("rot", exp_id[k], exp_res[k], exp_z[k]);
            step();
        end

        // Back-pressure: response held for 10 cycles
        do_reset();
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 3'b000, 32'(i + 1), 32'd10);
        bus.req_valid = 4'b1111;
        #1;
        check_val("bp_grant0", {60'd0, bus.req_ready}, 64'h1);
        step();
        bus.req_valid[0] = 1'b0;
        step();
        check_resp("bp_first", 2'd0, 32'd11, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            check_val("bp_hold_valid", {63'd0, bus.resp_valid}, 64'd1);
            check_val("bp_hold_id", {62'd0, bus.resp_id}, 64'd0);
            check_val("bp_hold_result", {32'd0, bus.resp_result}, 64'd11);
            check_val("bp_no_ready", {60'd0, bus.req_ready}, 64'd0);
            check_val("bp_hold_srca", {32'd0, bus.alu_srca}, 64'd1);
        end
        bus.resp_ready = 1'b1;
        step();
        check_val("bp_next_grant", {60'd0, bus.req_ready}, 64'h2);
        step();
        bus.req_valid = 4'b0000;
        step();
        check_resp("bp_second", 2'd1, 32'd12, 1'b0);
        step();

        // Wrap: pointer at 3 with requesters 0 and 3 valid
        do_reset();
        set_req(2, 3'b011, 32'h0F, 32'hF0);
        bus.req_valid = 4'b0100;
        #1;
        check_val("wrap_pre_grant", {60'd0, bus.req_ready}, 64'h4);
        step();
        bus.req_valid = 4'b0000;
        step();
        check_resp("wrap_pre", 2'd2, 32'hFF, 1'b0);
        step();
        set_req(0, 3'b001, 32'd10, 32'd3);
        set_req(3, 3'b000, 32'd20, 32'd22);
        bus.req_valid = 4'b1001;
        #1;
        check_val("wrap_grant3", {60'd0, bus.req_ready}, 64'h8);
        step();
        bus.req_valid[3] = 1'b0;
        step();
        check_resp("wrap_r3", 2'd3, 32'd42, 1'b0);
        step();
        check_val("wrap_grant0", {60'd0, bus.req_ready}, 64'h1);
        step();
        bus.req_valid = 4'b0000;
        step();
        check_resp("wrap_r0", 2'd0, 32'd7, 1'b0);
        step();

        // Reset during ISSUE aborts and restarts rotation at 0
        do_reset();
        set_req(1, 3'b000, 32'd1, 32'd1);
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = 4'b0000;
        step();
        step();
        set_req(0, 3'b000, 32'd5, 32'd7);
        set_req(3, 3'b001, 32'd30, 32'd4);
        bus.req_valid = 4'b1001;
        #1;
        check_val("abort_grant3", {60'd0, bus.req_ready}, 64'h8);
        step();
        check_val("abort_srca_issue", {32'd0, bus.alu_srca}, 64'd30);
        rst_n = 1'b0;
        #1;
        check_val("abort_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check_val("abort_req_ready", {60'd0, bus.req_ready}, 64'd0);
        check_val("abort_srca", {32'd0, bus.alu_srca}, 64'd0);
        check_val("abort_srcb", {32'd0, bus.alu_srcb}, 64'd0);
        check_val("abort_ctrl", {61'd0, bus.alu_ctrl}, 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check_val("abort_regrant0", {60'd0, bus.req_ready}, 64'h1);
        step();
        bus.req_valid[0] = 1'b0;
        step();
        check_resp("abort_r0", 2'd0, 32'd12, 1'b0);
        step();
        check_val("abort_regrant3", {60'd0, bus.req_ready}, 64'h8);
        step();
        bus.req_valid = 4'b0000;
        step();
        check_resp("abort_r3", 2'd3, 32'd26, 1'b0);
        step();

        // Reserved op 110, then a legal add
        do_reset();
        set_req(1, 3'b110, 32'd9, 32'd9);
        bus.req_valid = 4'b0010;
        #1;
        check_val("rsv_grant", {60'd0, bus.req_ready}, 64'h2);
        step();
        bus.req_valid = 4'b0000;
`ifdef ALU_SHARE_OPCHECK_EN
        check_resp("rsv_fast", 2'd1, 32'd0, 1'b0);
        check_val("rsv_err", {63'd0, bus.resp_err}, 64'd1);
        check_val("rsv_ctrl_kept", {61'd0, bus.alu_ctrl}, 64'd0);
        check_val("rsv_srca_kept", {32'd0, bus.alu_srca}, 64'd0);
        step();
        check_val("rsv_done", {63'd0, bus.resp_valid}, 64'd0);
`else
        check_val("rsv_issue_valid", {63'd0, bus.resp_valid}, 64'd0);
        check_val("rsv_issue_ctrl", {61'd0, bus.alu_ctrl}, 64'h6);
        step();
        check_resp("rsv_issued", 2'd1, 32'd0, 1'b1);
        step();
`endif
        set_req(2, 3'b000, 32'd2, 32'd3);
        bus.req_valid = 4'b0100;
        #1;
        check_val("post_rsv_grant", {60'd0, bus.req_ready}, 64'h4);
        step();
        bus.req_valid = 4'b0000;
        step();
        check_resp("post_rsv", 2'd2, 32'd5, 1'b0);
`ifdef ALU_SHARE_OPCHECK_EN
        check_val("post_rsv_err", {63'd0, bus.resp_err}, 64'd0);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
